// File: rtl/rtc_spi_responder.sv
`timescale 1ns/1ps
// rtc_spi_responder: SPI target for the cartridge RTC command protocol backed by an
// S-3511A-style register file. Define RTC_TICK_EN to let the Tick strobe advance the clock.
module rtc_spi_responder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  RESET_STATUS = 8'h00
) (
  input  logic        SClk,
  input  logic        nReset,
  input  logic        SPIClk,
  input  logic        nSPICs,
  input  logic        SPIMosi,
  output logic        SPIMiso,
  output logic        SPIMisoOE,
  output logic        Busy,
  output logic        CmdDone,
  output logic [7:0]  RegStatus,
  output logic [55:0] RegTime,
  output logic [15:0] RegAlarm,
  input  logic        Tick
);

  localparam logic [55:0] RESET_TIME = 56'h00_01_01_00_00_00_00;
  localparam logic [2:0] OP_RESET  = 3'd0;
  localparam logic [2:0] OP_STATUS = 3'd1;
  localparam logic [2:0] OP_DATA0  = 3'd2;
  localparam logic [2:0] OP_DATA4  = 3'd3;
  localparam logic [2:0] OP_MISC   = 3'd4;
  localparam logic [2:0] OP_NOP    = 3'd5;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic        clk_prev_q, clk_prev_d, cs_prev_q, cs_prev_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d, byte_idx_q, byte_idx_d;
  logic [6:0]  shift_q, shift_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        valid_q, valid_d, load_q, load_d, miso_q, miso_d, done_q, done_d;
  logic [7:0]  tx_q, tx_d;
  logic [55:0] snap_q, snap_d;
  logic [7:0]  status_q, status_d;
  logic [55:0] time_q, time_d, time_base;
  logic [15:0] alarm_q, alarm_d;

  logic       clk_s, cs_s, mosi_s;
  logic       clk_rise, clk_fall, cs_rise, cs_fall;
  logic [7:0] rx_byte, next_byte;
  logic       cmd_ok, last_bit;
  logic [2:0] wr_tgt;

  function automatic logic [2:0] op_len(input logic [2:0] op);
    case (op)
      OP_STATUS:       op_len = 3'd1;
      OP_DATA0:        op_len = 3'd7;
      OP_DATA4:        op_len = 3'd3;
      OP_MISC, OP_NOP: op_len = 3'd2;
      default:         op_len = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [55:0] v, input logic [2:0] idx);
    byte_at = 8'hFF;
    for (int k = 0; k < 7; k++)
      if (idx == 3'(k)) byte_at = v[8*(6-k) +: 8];
  endfunction

`ifdef RTC_TICK_EN
  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    bcd_inc = (b[3:0] == 4'd9) ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] month, input logic [7:0] year);
    logic leap;
    leap = year[4] ? (year[3:0] == 4'd2 || year[3:0] == 4'd6)
                   : (year[3:0] == 4'd0 || year[3:0] == 4'd4 || year[3:0] == 4'd8);
    case (month)
      8'h02:                      month_len = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      default:                    month_len = 8'h31;
    endcase
  endfunction

  // BCD ripple: each field only advances when every faster field wraps.
  function automatic logic [55:0] rtc_next(input logic [55:0] t);
    logic [7:0] yr, mo, dy, wd, hr, mi, se;
    {yr, mo, dy, wd, hr, mi, se} = t;
    if (se != 8'h59) se = bcd_inc(se);
    else begin
      se = 8'h00;
      if (mi != 8'h59) mi = bcd_inc(mi);
      else begin
        mi = 8'h00;
        if (hr != 8'h23) hr = bcd_inc(hr);
        else begin
          hr = 8'h00;
          wd = (wd >= 8'h06) ? 8'h00 : wd + 8'h01;
          if (dy < month_len(mo, yr)) dy = bcd_inc(dy);
          else begin
            dy = 8'h01;
            if (mo < 8'h12) mo = bcd_inc(mo);
            else begin
              mo = 8'h01;
              yr = (yr == 8'h99) ? 8'h00 : bcd_inc(yr);
            end
          end
        end
      end
    end
    rtc_next = {yr, mo, dy, wd, hr, mi, se};
  endfunction

  assign time_base = (Tick && !status_q[7]) ? rtc_next(time_q) : time_q;
`else
  logic tick_unused;
  assign tick_unused = Tick;
  assign time_base   = time_q;
`endif

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], SPIClk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], nSPICs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPIMosi};
    clk_s       = clk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    clk_prev_d  = clk_s;
    cs_prev_d   = cs_s;
    clk_rise    = clk_s & ~clk_prev_q;
    clk_fall    = ~clk_s & clk_prev_q;
    cs_rise     = cs_s & ~cs_prev_q;
    cs_fall     = ~cs_s & cs_prev_q;
    rx_byte     = {shift_q, mosi_s};
    last_bit    = (bit_cnt_q == 3'd7);
    cmd_ok      = (rx_byte[7:4] == 4'hF) && (rx_byte[3:1] <= OP_NOP);
    next_byte   = (byte_idx_q < op_len(cmd_q[3:1])) ? byte_at(snap_q, byte_idx_q) : 8'hFF;
    wr_tgt      = (cmd_q[3:1] == OP_DATA4) ? byte_idx_q + 3'd4 : byte_idx_q;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (cs_fall) state_d = CMD;
        CMD:     if (clk_rise && last_bit) state_d = cmd_ok ? DATA : DRAIN;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath and outputs; a read reloads tx on the first fall after each 8th rise.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    cmd_d      = cmd_q;
    valid_d    = valid_q;
    load_d     = load_q;
    miso_d     = miso_q;
    done_d     = 1'b0;
    tx_d       = tx_q;
    snap_d     = snap_q;
    status_d   = status_q;
    time_d     = time_base;
    alarm_d    = alarm_q;
    if (cs_rise) begin
      done_d  = valid_q;
      valid_d = 1'b0;
      load_d  = 1'b0;
      miso_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          bit_cnt_d = 3'd0;
          shift_d   = 7'd0;
          valid_d   = 1'b0;
          load_d    = 1'b0;
          miso_d    = 1'b1;
        end
        CMD: if (clk_rise) begin
          shift_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit && cmd_ok) begin
            cmd_d      = rx_byte[3:0];
            valid_d    = 1'b1;
            byte_idx_d = 3'd0;
            load_d     = rx_byte[0];
            case (rx_byte[3:1])
              OP_STATUS: snap_d = {status_q, 48'hFFFF_FFFF_FFFF};
              OP_DATA0:  snap_d = time_q;
              OP_DATA4:  snap_d = {time_q[23:0], 32'hFFFF_FFFF};
              OP_MISC:   snap_d = {alarm_q, 40'hFF_FFFF_FFFF};
              default:   snap_d = '1;
            endcase
            if (rx_byte[3:1] == OP_RESET) begin
              status_d = RESET_STATUS;
              time_d   = RESET_TIME;
              alarm_d  = 16'h0000;
            end
          end
        end
        DATA: begin
          if (clk_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              byte_idx_d = (byte_idx_q == 3'd7) ? 3'd7 : byte_idx_q + 3'd1;
              if (cmd_q[0]) load_d = 1'b1;
              else if (byte_idx_q < op_len(cmd_q[3:1])) begin
                case (cmd_q[3:1])
                  OP_STATUS: status_d = rx_byte;
                  OP_DATA0, OP_DATA4:
                    for (int k = 0; k < 7; k++)
                      if (wr_tgt == 3'(k)) time_d[8*(6-k) +: 8] = rx_byte;
                  OP_MISC:
                    if (byte_idx_q == 3'd0) alarm_d[15:8] = rx_byte;
                    else alarm_d[7:0] = rx_byte;
                  default: ;
                endcase
              end
            end
          end else if (clk_fall && cmd_q[0]) begin
            if (load_q) begin
              miso_d = next_byte[7];
              tx_d   = {next_byte[6:0], 1'b1};
              load_d = 1'b0;
            end else begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
    SPIMiso   = miso_q;
    SPIMisoOE = ~cs_s;
    Busy      = ~cs_s;
    CmdDone   = done_q;
    RegStatus = status_q;
    RegTime   = time_q;
    RegAlarm  = alarm_q;
  end

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= 3'd0;
      shift_q     <= 7'd0;
      cmd_q       <= 4'd0;
      valid_q     <= 1'b0;
      load_q      <= 1'b0;
      miso_q      <= 1'b1;
      done_q      <= 1'b0;
      tx_q        <= 8'hFF;
      snap_q      <= '1;
      status_q    <= RESET_STATUS;
      time_q      <= RESET_TIME;
      alarm_q     <= 16'h0000;
    end else begin
      clk_sync_q  <= clk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      clk_prev_q  <= clk_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      valid_q     <= valid_d;
      load_q      <= load_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
      snap_q      <= snap_d;
      status_q    <= status_d;
      time_q      <= time_d;
      alarm_q     <= alarm_d;
    end
  end

endmodule

// File: tb/tb_rtc_spi_responder.sv
`timescale 1ns/1ps
// Bench for rtc_spi_responder: directed vector table, multi-cycle corner sequences and
// randomized transactions checked against a register-level model of the protocol.
module tb_rtc_spi_responder;

  localparam int HALF = 6;
  localparam logic [55:0] RESET_TIME = 56'h00_01_01_00_00_00_00;
  localparam logic [63:0] ALL_FF = 64'hFFFF_FFFF_FFFF_FFFF;

  logic SClk = 1'b0;
  logic nReset, SPIClk, nSPICs, SPIMosi, Tick;
  logic SPIMiso, SPIMisoOE, Busy, CmdDone;
  logic [7:0]  RegStatus;
  logic [55:0] RegTime;
  logic [15:0] RegAlarm;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int done_base;
  logic busy_seen;
  logic [7:0] tx_buf [0:7];
  logic [7:0] rx_buf [0:7];

  logic [7:0] mdl_status;
  logic [7:0] mdl_time [0:6];
  logic [7:0] mdl_alarm [0:1];
  logic [7:0] mdl_rx [0:7];
  int mdl_done;

  typedef struct {
    logic [63:0] tx;
    int          n;
    int          pbits;
    logic [7:0]  pval;
    logic [63:0] exp_rx;
    logic [7:0]  exp_status;
    logic [55:0] exp_time;
    logic [15:0] exp_alarm;
    int          exp_done;
  } vec_t;
  vec_t vecs [0:17];

  rtc_spi_responder #(.SYNC_STAGES(2), .RESET_STATUS(8'h00)) dut (
    .SClk(SClk), .nReset(nReset), .SPIClk(SPIClk), .nSPICs(nSPICs), .SPIMosi(SPIMosi),
    .SPIMiso(SPIMiso), .SPIMisoOE(SPIMisoOE), .Busy(Busy), .CmdDone(CmdDone),
    .RegStatus(RegStatus), .RegTime(RegTime), .RegAlarm(RegAlarm), .Tick(Tick)
  );

  always #5 SClk = ~SClk;

  always @(negedge SClk) if (CmdDone === 1'b1) done_cnt++;

  initial begin
    repeat (200000) @(posedge SClk);
    $display("[TB] FAIL watchdog: simulation still running after 200000 cycles");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] v, input int nbits, output logic [7:0] r);
    r = 8'hFF;
    for (int b = 0; b < nbits; b++) begin
      SPIMosi = v[7-b];
      repeat (HALF) @(negedge SClk);
      r[7-b] = SPIMiso;
      SPIClk = 1'b1;
      repeat (HALF) @(negedge SClk);
      SPIClk = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input int n, input int pbits, input logic [7:0] pval);
    logic [7:0] r;
    done_base = done_cnt;
    for (int k = 0; k < 8; k++) rx_buf[k] = 8'hFF;
    nSPICs = 1'b0;
    repeat (HALF) @(negedge SClk);
    busy_seen = Busy & SPIMisoOE;
    for (int k = 0; k < n; k++) begin
      spi_byte(tx_buf[k], 8, r);
      rx_buf[k] = r;
    end
    if (pbits > 0) spi_byte(pval, pbits, r);
    repeat (HALF) @(negedge SClk);
    nSPICs = 1'b1;
    repeat (3 * HALF) @(negedge SClk);
  endtask

  function automatic logic [63:0] rx_word();
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[63-8*k -: 8] = rx_buf[k];
    return w;
  endfunction

  function automatic logic [63:0] mdl_rx_word();
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[63-8*k -: 8] = mdl_rx[k];
    return w;
  endfunction

  function automatic logic [55:0] mdl_time_word();
    logic [55:0] w;
    for (int k = 0; k < 7; k++) w[55-8*k -: 8] = mdl_time[k];
    return w;
  endfunction

  task automatic mdl_reset();
    mdl_status = 8'h00;
    mdl_time = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    mdl_alarm = '{8'h00, 8'h00};
  endtask

  // Protocol model: the command picks a byte list, data bytes walk it by index.
  task automatic model_txn(input int n);
    logic [7:0] cmd;
    logic [7:0] src [0:6];
    int op, len, idx;
    for (int k = 0; k < 8; k++) mdl_rx[k] = 8'hFF;
    mdl_done = 0;
    if (n == 0) return;
    cmd = tx_buf[0];
    op = int'(cmd[3:1]);
    if (cmd[7:4] != 4'hF || op > 5) return;
    mdl_done = 1;
    len = (op == 1) ? 1 : (op == 2) ? 7 : (op == 3) ? 3 : (op >= 4) ? 2 : 0;
    if (op == 0) mdl_reset();
    for (int k = 0; k < 7; k++) src[k] = 8'hFF;
    case (op)
      1: src[0] = mdl_status;
      2: for (int k = 0; k < 7; k++) src[k] = mdl_time[k];
      3: for (int k = 0; k < 3; k++) src[k] = mdl_time[4+k];
      4: begin src[0] = mdl_alarm[0]; src[1] = mdl_alarm[1]; end
      default: ;
    endcase
    for (int i = 1; i < n; i++) begin
      idx = i - 1;
      if (idx < len) begin
        if (cmd[0]) mdl_rx[i] = src[idx];
        else case (op)
          1: mdl_status = tx_buf[i];
          2: mdl_time[idx] = tx_buf[i];
          3: mdl_time[4+idx] = tx_buf[i];
          4: mdl_alarm[idx] = tx_buf[i];
          default: ;
        endcase
      end
    end
  endtask

  task automatic write_time(input logic [55:0] t);
    tx_buf[0] = 8'hF4;
    for (int k = 0; k < 7; k++) tx_buf[k+1] = t[55-8*k -: 8];
    apply_stimulus(8, 0, 8'h00);
  endtask

  task automatic write_status(input logic [7:0] s);
    tx_buf[0] = 8'hF2;
    tx_buf[1] = s;
    apply_stimulus(2, 0, 8'h00);
  endtask

  task automatic tick_case(input string name, input logic [55:0] start, input logic [55:0] exp);
    write_time(start);
    @(negedge SClk) Tick = 1'b1;
    @(negedge SClk) Tick = 1'b0;
    repeat (2) @(negedge SClk);
    check_output(name, 64'(RegTime), 64'(exp));
  endtask

  initial begin
    logic [7:0] r;
    int n, pbits;
    vecs[0]  = '{64'hF4_24_12_31_02_23_59_58, 8, 0, 8'h00, ALL_FF, 8'h00, 56'h24_12_31_02_23_59_58, 16'h0000, 1};
    vecs[1]  = '{64'hF7_FF_FF_FF_FF_00_00_00, 5, 0, 8'h00, 64'hFF_23_59_58_FF_FF_FF_FF, 8'h00, 56'h24_12_31_02_23_59_58, 16'h0000, 1};
    vecs[2]  = '{64'hF2_80_00_00_00_00_00_00, 2, 0, 8'h00, ALL_FF, 8'h80, 56'h24_12_31_02_23_59_58, 16'h0000, 1};
    vecs[3]  = '{64'hF3_FF_FF_00_00_00_00_00, 3, 0, 8'h00, 64'hFF_80_FF_FF_FF_FF_FF_FF, 8'h80, 56'h24_12_31_02_23_59_58, 16'h0000, 1};
    vecs[4]  = '{64'hF8_AB_CD_00_00_00_00_00, 3, 0, 8'h00, ALL_FF, 8'h80, 56'h24_12_31_02_23_59_58, 16'hABCD, 1};
    vecs[5]  = '{64'hF0_00_00_00_00_00_00_00, 1, 0, 8'h00, ALL_FF, 8'h00, RESET_TIME, 16'h0000, 1};
    vecs[6]  = '{64'hFC_FF_FF_00_00_00_00_00, 3, 0, 8'h00, ALL_FF, 8'h00, RESET_TIME, 16'h0000, 0};
    vecs[7]  = '{64'hA4_11_22_00_00_00_00_00, 3, 0, 8'h00, ALL_FF, 8'h00, RESET_TIME, 16'h0000, 0};
    vecs[8]  = '{64'hF8_12_00_00_00_00_00_00, 2, 5, 8'h34, ALL_FF, 8'h00, RESET_TIME, 16'h1200, 1};
    vecs[9]  = '{64'hF9_FF_FF_FF_00_00_00_00, 4, 0, 8'h00, 64'hFF_12_00_FF_FF_FF_FF_FF, 8'h00, RESET_TIME, 16'h1200, 1};
    vecs[10] = '{64'hF6_10_20_30_40_00_00_00, 5, 0, 8'h00, ALL_FF, 8'h00, 56'h00_01_01_00_10_20_30, 16'h1200, 1};
    vecs[11] = '{64'hFA_55_66_00_00_00_00_00, 3, 0, 8'h00, ALL_FF, 8'h00, 56'h00_01_01_00_10_20_30, 16'h1200, 1};
    vecs[12] = '{64'hFB_FF_FF_FF_00_00_00_00, 4, 0, 8'h00, ALL_FF, 8'h00, 56'h00_01_01_00_10_20_30, 16'h1200, 1};
    vecs[13] = '{64'h00_00_00_00_00_00_00_00, 0, 0, 8'h00, ALL_FF, 8'h00, 56'h00_01_01_00_10_20_30, 16'h1200, 0};
    vecs[14] = '{64'h00_00_00_00_00_00_00_00, 0, 4, 8'hF4, ALL_FF, 8'h00, 56'h00_01_01_00_10_20_30, 16'h1200, 0};
    vecs[15] = '{64'hF5_FF_FF_FF_FF_FF_FF_FF, 8, 0, 8'h00, 64'hFF_00_01_01_00_10_20_30, 8'h00, 56'h00_01_01_00_10_20_30, 16'h1200, 1};
    vecs[16] = '{64'hF2_11_22_00_00_00_00_00, 3, 0, 8'h00, ALL_FF, 8'h11, 56'h00_01_01_00_10_20_30, 16'h1200, 1};
    vecs[17] = '{64'hF3_FF_FF_FF_FF_FF_FF_FF, 8, 0, 8'h00, 64'hFF_11_FF_FF_FF_FF_FF_FF, 8'h11, 56'h00_01_01_00_10_20_30, 16'h1200, 1};

    nReset = 1'b0; SPIClk = 1'b0; nSPICs = 1'b1; SPIMosi = 1'b0; Tick = 1'b0;
    repeat (3) @(negedge SClk);
    check_output("reset miso", 64'(SPIMiso), 64'd1);
    check_output("reset oe", 64'(SPIMisoOE), 64'd0);
    check_output("reset busy", 64'(Busy), 64'd0);
    check_output("reset done", 64'(CmdDone), 64'd0);
    check_output("reset status", 64'(RegStatus), 64'h00);
    check_output("reset time", 64'(RegTime), 64'(RESET_TIME));
    check_output("reset alarm", 64'(RegAlarm), 64'h0);
    nReset = 1'b1;
    repeat (4) @(negedge SClk);

    for (int i = 0; i < 18; i++) begin
      for (int k = 0; k < 8; k++) tx_buf[k] = vecs[i].tx[63-8*k -: 8];
      apply_stimulus(vecs[i].n, vecs[i].pbits, vecs[i].pval);
      check_output($sformatf("vec%0d busy", i), 64'(busy_seen), 64'd1);
      check_output($sformatf("vec%0d rx", i), rx_word(), vecs[i].exp_rx);
      check_output($sformatf("vec%0d status", i), 64'(RegStatus), 64'(vecs[i].exp_status));
      check_output($sformatf("vec%0d time", i), 64'(RegTime), 64'(vecs[i].exp_time));
      check_output($sformatf("vec%0d alarm", i), 64'(RegAlarm), 64'(vecs[i].exp_alarm));
      check_output($sformatf("vec%0d done", i), 64'(done_cnt - done_base), 64'(vecs[i].exp_done));
    end

`ifdef RTC_TICK_EN
    tick_case("tick rollover", 56'h99_12_31_06_23_59_59, 56'h00_01_01_00_00_00_00);
    tick_case("tick leap", 56'h24_02_28_03_23_59_59, 56'h24_02_29_04_00_00_00);
    tick_case("tick nonleap", 56'h23_02_28_03_23_59_59, 56'h23_03_01_04_00_00_00);
    tick_case("tick month30", 56'h24_04_30_05_23_59_59, 56'h24_05_01_06_00_00_00);
    tick_case("tick sec", 56'h24_05_10_01_12_34_09, 56'h24_05_10_01_12_34_10);
    write_status(8'h80);
    tick_case("tick stopped", 56'h24_05_10_01_12_34_09, 56'h24_05_10_01_12_34_09);
    write_status(8'h11);
`else
    tick_case("tick ignored", 56'h99_12_31_06_23_59_59, 56'h99_12_31_06_23_59_59);
`endif

    // Asynchronous reset in the middle of a command byte.
    nSPICs = 1'b0;
    repeat (HALF) @(negedge SClk);
    spi_byte(8'hF8, 3, r);
    nReset = 1'b0;
    #1;
    check_output("midrst miso", 64'(SPIMiso), 64'd1);
    check_output("midrst oe", 64'(SPIMisoOE), 64'd0);
    check_output("midrst busy", 64'(Busy), 64'd0);
    check_output("midrst status", 64'(RegStatus), 64'h00);
    check_output("midrst time", 64'(RegTime), 64'(RESET_TIME));
    check_output("midrst alarm", 64'(RegAlarm), 64'h0);
    repeat (HALF) @(negedge SClk);
    nSPICs = 1'b1;
    repeat (HALF) @(negedge SClk);
    nReset = 1'b1;
    repeat (HALF) @(negedge SClk);
    write_status(8'h5A);
    check_output("postrst status", 64'(RegStatus), 64'h5A);
    check_output("postrst done", 64'(done_cnt - done_base), 64'd1);
    check_output("postrst alarm", 64'(RegAlarm), 64'h0);

    mdl_reset();
    mdl_status = 8'h5A;
    for (int t = 0; t < 30; t++) begin
      n = int'($urandom_range(0, 8));
      pbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int k = 0; k < 8; k++) tx_buf[k] = 8'($urandom);
      if ($urandom_range(0, 4) != 0) tx_buf[0] = {4'hF, 4'($urandom_range(0, 15))};
      if (tx_buf[0][3:1] == 3'd0 && $urandom_range(0, 2) != 0) tx_buf[0][3:1] = 3'd2;
      model_txn(n);
      apply_stimulus(n, pbits, 8'($urandom));
      check_output($sformatf("rand%0d rx", t), rx_word(), mdl_rx_word());
      check_output($sformatf("rand%0d status", t), 64'(RegStatus), 64'(mdl_status));
      check_output($sformatf("rand%0d time", t), 64'(RegTime), 64'(mdl_time_word()));
      check_output($sformatf("rand%0d alarm", t), 64'(RegAlarm), 64'({mdl_alarm[0], mdl_alarm[1]}));
      check_output($sformatf("rand%0d done", t), 64'(done_cnt - done_base), 64'(mdl_done));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
